// File: rtl/normalize_round_pack_if.sv
// rtl/normalize_round_pack_if.sv - Load/Done operand and result bundle for the FP add normalize/round/pack stage
interface normalize_round_pack_if;
    logic        Load;
    logic        S_In;
    logic [7:0]  E_In;
    logic [23:0] M_In;
    logic        Carry_In;
    logic        guard_In;
    logic        round_In;
    logic        sticky_In;
    logic [31:0] Result;
    logic        Done;
    logic        Busy;
    logic        Overflow;
    logic        Underflow;
    logic        Inexact;

    modport master (
        output Load, S_In, E_In, M_In, Carry_In, guard_In, round_In, sticky_In,
        input  Result, Done, Busy, Overflow, Underflow, Inexact
    );

    modport slave (
        input  Load, S_In, E_In, M_In, Carry_In, guard_In, round_In, sticky_In,
        output Result, Done, Busy, Overflow, Underflow, Inexact
    );
endinterface

// File: rtl/normalize_round_pack.sv
// rtl/normalize_round_pack.sv - multi-cycle normalize, round-to-nearest-even and binary32 pack
module normalize_round_pack (
    input  logic                     Clk,
    input  logic                     Reset,
    normalize_round_pack_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, CHECK, NORM, ROUND, PACK} state_t;

    state_t      state, state_next;

    logic        s;
    logic [8:0]  e;
    logic [23:0] m;
    logic        g, r, st;
    logic        carry;
    logic        special;
    logic        bypass;
    logic [31:0] bypass_word;
    logic        inexact_w;

    logic [23:0] norm_m;
    logic [8:0]  norm_e;
    logic        inc;
    logic        is_zero;

    assign norm_m  = {m[22:0], g};
    assign norm_e  = e - 9'd1;
    assign inc     = g & (r | st | m[0]);
    assign is_zero = (m == 24'd0) && !g && !r && !st;

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Carry and E=255 are decided before the zero test so an inf/NaN or carried sum never looks like zero.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.Load) state_next = CHECK;
            CHECK: begin
                if (special)                         state_next = PACK;
                else if (carry)                      state_next = ROUND;
                else if (is_zero)                    state_next = PACK;
                else if (m[23] || (e == 9'd1))       state_next = ROUND;
                else                                 state_next = NORM;
            end
            NORM:  if (norm_m[23] || (norm_e == 9'd1)) state_next = ROUND;
            ROUND: state_next = PACK;
            PACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s             <= 1'b0;
            e             <= 9'd0;
            m             <= 24'd0;
            g             <= 1'b0;
            r             <= 1'b0;
            st            <= 1'b0;
            carry         <= 1'b0;
            special       <= 1'b0;
            bypass        <= 1'b0;
            bypass_word   <= 32'd0;
            inexact_w     <= 1'b0;
            bus.Result    <= 32'd0;
            bus.Done      <= 1'b0;
            bus.Busy      <= 1'b0;
            bus.Overflow  <= 1'b0;
            bus.Underflow <= 1'b0;
            bus.Inexact   <= 1'b0;
        end else begin
            bus.Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Load) begin
                        s         <= bus.S_In;
                        // A zero exponent field carries the same scale as exponent 1 (subnormal).
                        e         <= (bus.E_In == 8'd0) ? 9'd1 : {1'b0, bus.E_In};
                        m         <= bus.M_In;
                        g         <= bus.guard_In;
                        r         <= bus.round_In;
                        st        <= bus.sticky_In;
                        carry     <= bus.Carry_In;
                        special   <= (bus.E_In == 8'hFF);
                        bypass    <= 1'b0;
                        inexact_w <= 1'b0;
                        bus.Busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (special) begin
                        bypass      <= 1'b1;
                        bypass_word <= {s, 8'hFF, m[22:0]};
                    end else if (carry) begin
                        m  <= {1'b1, m[23:1]};
                        g  <= m[0];
                        r  <= g;
                        st <= r | st;
                        e  <= e + 9'd1;
                    end else if (is_zero) begin
                        bypass      <= 1'b1;
                        bypass_word <= {s, 31'd0};
                    end
                end
                NORM: begin
                    m <= norm_m;
                    g <= r;
                    r <= 1'b0;
                    e <= norm_e;
                end
                ROUND: begin
                    inexact_w <= g | r | st;
                    if (inc && (m == 24'hFFFFFF)) begin
                        m <= 24'h800000;
                        e <= e + 9'd1;
                    end else begin
                        m <= m + {23'd0, inc};
                    end
                end
                PACK: begin
                    bus.Done <= 1'b1;
                    bus.Busy <= 1'b0;
                    if (bypass) begin
                        bus.Result    <= bypass_word;
                        bus.Overflow  <= 1'b0;
                        bus.Underflow <= 1'b0;
                        bus.Inexact   <= 1'b0;
                    end else if (e >= 9'd255) begin
                        bus.Result    <= {s, 8'hFF, 23'd0};
                        bus.Overflow  <= 1'b1;
                        bus.Underflow <= 1'b0;
                        bus.Inexact   <= inexact_w;
                    end else if (!m[23]) begin
                        bus.Result    <= {s, 8'h00, m[22:0]};
                        bus.Overflow  <= 1'b0;
                        bus.Underflow <= 1'b1;
                        bus.Inexact   <= inexact_w;
                    end else begin
                        bus.Result    <= {s, e[7:0], m[22:0]};
                        bus.Overflow  <= 1'b0;
                        bus.Underflow <= 1'b0;
                        bus.Inexact   <= inexact_w;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_round_pack.sv
// tb/tb_normalize_round_pack.sv - directed self-checking bench for normalize_round_pack
module tb_normalize_round_pack;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    normalize_round_pack_if bus ();

    normalize_round_pack dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s_%s observed=%h expected=%h", tag, what, obs, expv);
        end
    endtask

    task automatic drive(input logic sgn, input logic [7:0] ex, input logic [23:0] mn,
                         input logic cy, input logic gd, input logic rd, input logic sk);
        bus.S_In      = sgn;
        bus.E_In      = ex;
        bus.M_In      = mn;
        bus.Carry_In  = cy;
        bus.guard_In  = gd;
        bus.round_In  = rd;
        bus.sticky_In = sk;
    endtask

    task automatic scramble();
        drive(1'($urandom), 8'($urandom), 24'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [7:0] ex, input logic [23:0] mn,
                          input logic cy, input logic gd, input logic rd, input logic sk,
                          input logic [31:0] exp_res, input int exp_lat,
                          input logic exp_ov, input logic exp_un, input logic exp_ix);
        int lat;
        @(negedge Clk);
        drive(sgn, ex, mn, cy, gd, rd, sk);
        bus.Load = 1'b1;
        @(posedge Clk);
        #1;
        bus.Load = 1'b0;
        scramble();
        chk(tag, "busy_set", 32'(bus.Busy), 32'd1);
        lat = 0;
        for (int n = 1; (n <= 64) && (lat == 0); n++) begin
            @(posedge Clk);
            #1;
            if (bus.Done) lat = n;
        end
        chk(tag, "latency", 32'(lat), 32'(exp_lat));
        chk(tag, "result", bus.Result, exp_res);
        chk(tag, "overflow", 32'(bus.Overflow), 32'(exp_ov));
        chk(tag, "underflow", 32'(bus.Underflow), 32'(exp_un));
        chk(tag, "inexact", 32'(bus.Inexact), 32'(exp_ix));
        chk(tag, "busy_clr", 32'(bus.Busy), 32'd0);
        @(posedge Clk);
        #1;
        chk(tag, "done_pulse", 32'(bus.Done), 32'd0);
        chk(tag, "result_hold", bus.Result, exp_res);
    endtask

    initial begin
        int lat;
        int dones;
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        bus.Load = 1'b0;
        drive(1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        chk("reset", "result", bus.Result, 32'd0);
        chk("reset", "flags", {27'd0, bus.Done, bus.Busy, bus.Overflow, bus.Underflow, bus.Inexact}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        run_op("one_plus_one", 1'b0, 8'd127, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40000000, 3, 1'b0, 1'b0, 1'b0);
        run_op("cancel",       1'b0, 8'd127, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h34000000, 26, 1'b0, 1'b0, 1'b0);
        run_op("round_tie_b",  1'b0, 8'd127, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3F800000, 3, 1'b0, 1'b0, 1'b1);
        run_op("overflow",     1'b1, 8'd254, 24'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFF800000, 3, 1'b1, 1'b0, 1'b1);
        run_op("zero",         1'b0, 8'd0,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 2, 1'b0, 1'b0, 1'b0);
        run_op("subnormal",    1'b0, 8'd3,   24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000004, 5, 1'b0, 1'b1, 1'b0);
        run_op("special_nan",  1'b0, 8'd255, 24'h400001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7FC00001, 2, 1'b0, 1'b0, 1'b0);
        run_op("neg_zero",     1'b1, 8'd90,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 2, 1'b0, 1'b0, 1'b0);
        run_op("round_tie_a",  1'b0, 8'd127, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40000000, 3, 1'b0, 1'b0, 1'b1);

        // Load held high while busy: only the first operation may complete.
        @(negedge Clk);
        drive(1'b0, 8'd127, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.Load = 1'b1;
        @(posedge Clk);
        #1;
        drive(1'b1, 8'd255, 24'h123456, 1'b1, 1'b1, 1'b1, 1'b1);
        lat   = 0;
        dones = 0;
        for (int n = 1; n <= 64; n++) begin
            @(posedge Clk);
            #1;
            if (n == 10) bus.Load = 1'b0;
            if (bus.Done) begin
                dones++;
                if (lat == 0) lat = n;
            end
        end
        chk("busy_load", "latency", 32'(lat), 32'd26);
        chk("busy_load", "done_count", 32'(dones), 32'd1);
        chk("busy_load", "result", bus.Result, 32'h34000000);

        // Reset mid-NORM, with Load asserted in the same cycle.
        run_op("pre_reset", 1'b0, 8'd127, 24'hFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40000000, 3, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        drive(1'b0, 8'd127, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.Load = 1'b1;
        @(posedge Clk);
        #1;
        bus.Load = 1'b0;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Reset    = 1'b1;
        bus.Load = 1'b1;
        @(posedge Clk);
        #1;
        chk("mid_reset", "result", bus.Result, 32'd0);
        chk("mid_reset", "flags", {27'd0, bus.Done, bus.Busy, bus.Overflow, bus.Underflow, bus.Inexact}, 32'd0);
        @(negedge Clk);
        Reset    = 1'b0;
        bus.Load = 1'b0;
        dones    = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge Clk);
            #1;
            if (bus.Done || bus.Busy) dones++;
        end
        chk("mid_reset", "no_activity", 32'(dones), 32'd0);
        run_op("post_reset", 1'b0, 8'd3, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000004, 5, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
